// File: rtl/dither_engine_if.sv
// Pixel stream in, dithered pixel stream out, and the downward error
// writeback toward the line buffer, bundled for the dither engine.
interface dither_engine_if;
  logic              [7:0]  pix_in;
  logic              [10:0] pix_hcount;
  logic              [9:0]  pix_vcount;
  logic                     pix_valid;
  logic                     pix_ready;
  logic                     dith_out;
  logic              [10:0] dith_hcount;
  logic              [9:0]  dith_vcount;
  logic                     dith_valid;
  logic signed       [7:0]  wb_err;
  logic              [10:0] wb_hcount;
  logic              [9:0]  wb_vcount;
  logic                     wb_valid;

  modport master (
    output pix_in, pix_hcount, pix_vcount, pix_valid,
    input  pix_ready,
    input  dith_out, dith_hcount, dith_vcount, dith_valid,
    input  wb_err, wb_hcount, wb_vcount, wb_valid
  );

  modport slave (
    input  pix_in, pix_hcount, pix_vcount, pix_valid,
    output pix_ready,
    output dith_out, dith_hcount, dith_vcount, dith_valid,
    output wb_err, wb_hcount, wb_vcount, wb_valid
  );
endinterface

// File: rtl/dither_engine.sv
// Floyd-Steinberg style 1-bit dither engine. The rightward error (7/16) is
// carried in a register; the downward errors (3/16, 5/16, 1/16) are combined
// into one writeback per column, one column behind the input. After the last
// column of a line, a one-cycle FLUSH emits the final column's writeback.
module dither_engine #(
  parameter int FRAME_WIDTH  = 240,
  parameter int FRAME_HEIGHT = 320,
  parameter int THRESHOLD    = 128
) (
  input logic            clk_in,
  input logic            rst_in,
  dither_engine_if.slave bus
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [10:0] LAST_COL = 11'(FRAME_WIDTH - 1);
  localparam logic [9:0]  LAST_ROW = 10'(FRAME_HEIGHT - 1);
  localparam logic [7:0]  THR      = 8'(THRESHOLD);

  state_t state, state_next;
  logic   ready;
  logic   acc;

  logic signed [7:0]  carry;
  logic signed [8:0]  e1, e2;
  logic        [9:0]  row;

  logic signed [7:0]  carry_use;
  logic signed [8:0]  e1_use, e2_use;
  logic signed [10:0] v_sum;
  logic        [7:0]  vc;
  logic               hi;
  logic        [8:0]  diff;
  logic signed [8:0]  err;
  logic signed [12:0] err13, e1u13, e2u13, e1r13, e2r13;
  logic signed [12:0] carry_full, wb_acc_full, wb_flush_full;

  // Clamp the carried sum into the 8-bit pixel range.
  function automatic logic [7:0] clamp_pix(input logic signed [10:0] v);
    if (v < 11'sd0)   return 8'd0;
    if (v > 11'sd255) return 8'd255;
    return v[7:0];
  endfunction

  // Divide by 16 rounding toward minus infinity.
  function automatic logic signed [12:0] floor_div16(input logic signed [12:0] x);
    return x >>> 4;
  endfunction

  assign bus.pix_ready = ready;
  assign acc = bus.pix_valid && ready;

  // State register: RUN accepts pixels, FLUSH is the single end-of-line bubble.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= RUN;
    else        state <= state_next;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    case (state)
      RUN: begin
        ready = 1'b1;
        if (acc && bus.pix_hcount == LAST_COL) state_next = FLUSH;
      end
      FLUSH: state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Quantise the incoming pixel and form the carry and writeback sums.
  always_comb begin
    carry_use = (bus.pix_hcount == 11'd0) ? 8'sd0 : carry;
    e1_use    = (bus.pix_hcount == 11'd0) ? 9'sd0 : e1;
    e2_use    = (bus.pix_hcount == 11'd0) ? 9'sd0 : e2;
    v_sum     = $signed({3'b000, bus.pix_in}) + $signed({{3{carry_use[7]}}, carry_use});
    vc        = clamp_pix(v_sum);
    hi        = (vc >= THR);
    diff      = {1'b0, vc} - (hi ? 9'd255 : 9'd0);
    err       = $signed(diff);
    err13     = $signed({{4{err[8]}}, err});
    e1u13     = $signed({{4{e1_use[8]}}, e1_use});
    e2u13     = $signed({{4{e2_use[8]}}, e2_use});
    e1r13     = $signed({{4{e1[8]}}, e1});
    e2r13     = $signed({{4{e2[8]}}, e2});
    carry_full    = floor_div16(err13 * 13'sd7);
    wb_acc_full   = floor_div16(err13 * 13'sd3 + e1u13 * 13'sd5 + e2u13);
    wb_flush_full = floor_div16(e1r13 * 13'sd5 + e2r13);
  end

  // Error history and the registered one-cycle-latency outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      carry           <= '0;
      e1              <= '0;
      e2              <= '0;
      row             <= '0;
      bus.dith_out    <= 1'b0;
      bus.dith_hcount <= '0;
      bus.dith_vcount <= '0;
      bus.dith_valid  <= 1'b0;
      bus.wb_err      <= '0;
      bus.wb_hcount   <= '0;
      bus.wb_vcount   <= '0;
      bus.wb_valid    <= 1'b0;
    end else begin
      bus.dith_valid <= acc;
      bus.wb_valid   <= 1'b0;
      if (acc) begin
        carry           <= carry_full[7:0];
        e1              <= err;
        e2              <= e1_use;
        row             <= bus.pix_vcount;
        bus.dith_out    <= hi;
        bus.dith_hcount <= bus.pix_hcount;
        bus.dith_vcount <= bus.pix_vcount;
        bus.wb_valid    <= (bus.pix_hcount != 11'd0) && (bus.pix_vcount != LAST_ROW);
        bus.wb_err      <= wb_acc_full[7:0];
        bus.wb_hcount   <= bus.pix_hcount - 11'd1;
        bus.wb_vcount   <= bus.pix_vcount + 10'd1;
      end else if (state == FLUSH) begin
        bus.wb_valid    <= (row != LAST_ROW);
        bus.wb_err      <= wb_flush_full[7:0];
        bus.wb_hcount   <= LAST_COL;
        bus.wb_vcount   <= row + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_dither_engine.sv
// Directed bench for dither_engine with a queue-based scoreboard fed by a
// behavioural integer model of the error-diffusion arithmetic.
module tb_dither_engine;

  localparam int W = 240;
  localparam int H = 320;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  dither_engine_if bus ();

  dither_engine #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .THRESHOLD(128)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit dv;
    bit dout;
    int dh;
    int drow;
    bit wbv;
    int werr;
    int wh;
    int wv;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  int m_carry = 0;
  int m_e1    = 0;
  int m_e2    = 0;
  int m_row   = 0;
  bit m_flush = 0;

  int dcnt;
  int wcnt;

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int fdiv16(input int x);
    if (x >= 0) return x / 16;
    return -((-x + 15) / 16);
  endfunction

  task automatic model_reset();
    sb.delete();
    m_carry = 0;
    m_e1    = 0;
    m_e2    = 0;
    m_row   = 0;
    m_flush = 0;
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() > 0) e = sb.pop_front();
    else e = '{dv: 0, dout: 0, dh: 0, drow: 0, wbv: 0, werr: 0, wh: 0, wv: 0};
    chk("dith_valid", int'(bus.dith_valid), int'(e.dv));
    if (e.dv) begin
      chk("dith_out", int'(bus.dith_out), int'(e.dout));
      chk("dith_hcount", int'(bus.dith_hcount), e.dh);
      chk("dith_vcount", int'(bus.dith_vcount), e.drow);
    end
    chk("wb_valid", int'(bus.wb_valid), int'(e.wbv));
    if (e.wbv) begin
      chk("wb_err", int'(bus.wb_err), e.werr);
      chk("wb_hcount", int'(bus.wb_hcount), e.wh);
      chk("wb_vcount", int'(bus.wb_vcount), e.wv);
    end
  endtask

  // Offer one input for one clock; the model predicts what the next edge yields.
  task automatic drive(input bit valid, input int pix, input int h, input int v);
    exp_t e;
    int c, a1, a2, s, vc, q, err;
    bus.pix_valid  = valid;
    bus.pix_in     = 8'(pix);
    bus.pix_hcount = 11'(h);
    bus.pix_vcount = 10'(v);
    chk("pix_ready", int'(bus.pix_ready), m_flush ? 0 : 1);
    if (m_flush) begin
      e = '{dv: 0, dout: 0, dh: 0, drow: 0,
            wbv: (m_row != H - 1), werr: fdiv16(5 * m_e1 + m_e2),
            wh: W - 1, wv: m_row + 1};
      sb.push_back(e);
      m_flush = 0;
    end else if (valid) begin
      c   = (h == 0) ? 0 : m_carry;
      a1  = (h == 0) ? 0 : m_e1;
      a2  = (h == 0) ? 0 : m_e2;
      s   = pix + c;
      vc  = (s < 0) ? 0 : ((s > 255) ? 255 : s);
      q   = (vc >= 128) ? 255 : 0;
      err = vc - q;
      e = '{dv: 1, dout: (q == 255), dh: h, drow: v,
            wbv: (h != 0) && (v != H - 1), werr: fdiv16(3 * err + 5 * a1 + a2),
            wh: h - 1, wv: v + 1};
      sb.push_back(e);
      m_carry = fdiv16(7 * err);
      m_e2    = a1;
      m_e1    = err;
      m_row   = v;
      if (h == W - 1) m_flush = 1;
    end
    @(posedge clk_in);
    #1;
    check_out();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pix_valid  = 1'b0;
    bus.pix_in     = '0;
    bus.pix_hcount = '0;
    bus.pix_vcount = '0;
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    chk("reset pix_ready", int'(bus.pix_ready), 1);
    chk("reset dith_valid", int'(bus.dith_valid), 0);
    chk("reset wb_valid", int'(bus.wb_valid), 0);
    chk("reset wb_err", int'(bus.wb_err), 0);
    rst_in = 1'b0;
    drive(0, 0, 0, 0);

    // Basic arithmetic and clamp on row 0.
    drive(1, 200, 0, 0);
    chk("arith1 dith_out", int'(bus.dith_out), 1);
    chk("arith1 wb_valid", int'(bus.wb_valid), 0);
    drive(1, 100, 1, 0);
    chk("arith2 dith_out", int'(bus.dith_out), 0);
    chk("arith2 wb_err", int'(bus.wb_err), -4);
    chk("arith2 wb_hcount", int'(bus.wb_hcount), 0);
    chk("arith2 wb_vcount", int'(bus.wb_vcount), 1);
    drive(1, 250, 2, 0);
    chk("clamp dith_out", int'(bus.dith_out), 1);
    chk("clamp wb_err", int'(bus.wb_err), 20);
    chk("clamp wb_hcount", int'(bus.wb_hcount), 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    // Line start zeroes carry and history even though carry is nonzero.
    for (int h = 0; h < 4; h++) drive(1, 100, h, 7);
    drive(1, 100, 0, 8);
    chk("linestart dith_out", int'(bus.dith_out), 0);
    chk("linestart wb_valid", int'(bus.wb_valid), 0);

    // Full zero line on row 5; a pixel is offered during the flush bubble.
    for (int h = 0; h < W; h++) drive(1, 0, h, 5);
    drive(1, 255, 0, 6);
    chk("flush dith_valid", int'(bus.dith_valid), 0);
    chk("flush wb_valid", int'(bus.wb_valid), 1);
    chk("flush wb_err", int'(bus.wb_err), 0);
    chk("flush wb_hcount", int'(bus.wb_hcount), 239);
    chk("flush wb_vcount", int'(bus.wb_vcount), 6);
    drive(1, 255, 0, 6);
    chk("post-flush accept", int'(bus.dith_valid), 1);

    // Last row: dithered output only, flush still blocks.
    dcnt = 0;
    wcnt = 0;
    for (int h = 0; h < W; h++) begin
      drive(1, (h * 37 + 11) % 256, h, H - 1);
      if (bus.dith_valid) dcnt++;
      if (bus.wb_valid) wcnt++;
    end
    drive(1, 50, 0, 0);
    if (bus.wb_valid) wcnt++;
    chk("lastrow dith count", dcnt, W);
    chk("lastrow wb count", wcnt, 0);
    drive(0, 0, 0, 0);

    // Random-ish row with input bubbles.
    for (int h = 0; h < W; h++) begin
      while ($urandom_range(0, 3) == 0) drive(0, 0, h, 12);
      drive(1, int'($urandom_range(0, 255)), h, 12);
    end
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    // Reset while in FLUSH acts immediately and discards history.
    drive(1, 80, W - 2, 9);
    drive(1, 80, W - 1, 9);
    chk("preflush pix_ready", int'(bus.pix_ready), 0);
    rst_in = 1'b1;
    #1;
    chk("rst async pix_ready", int'(bus.pix_ready), 1);
    chk("rst async dith_valid", int'(bus.dith_valid), 0);
    chk("rst async wb_valid", int'(bus.wb_valid), 0);
    model_reset();
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    drive(1, 60, 5, 2);
    chk("post-reset wb_err", int'(bus.wb_err), 11);
    chk("post-reset wb_hcount", int'(bus.wb_hcount), 4);
    chk("post-reset wb_vcount", int'(bus.wb_vcount), 3);
    drive(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
